// File: rtl/full_adder_pkg.sv
// ============================================================================
// full_adder_pkg : bit-level full-adder equations shared by the adder cells
// Rev 1.0
// ============================================================================
`default_nettype none

package full_adder_pkg;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (c & (a ^ b));
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
// full_adder_cell : 1-bit combinational full adder (a + b + cin -> s, cout)
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = fa_sum(a, b, cin);
    assign cout = fa_carry(a, b, cin);

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// full_adder : WIDTH-bit ripple-carry adder with optional output register
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_carry[i]),
            .s    (w_sum[i]),
            .cout (w_carry[i+1])
        );
    end

    // For WIDTH=1 the carry into the MSB is cin itself.
    assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] r_out;
        logic             r_cout;
        logic             r_ovf;

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                r_out  <= '0;
                r_cout <= 1'b0;
                r_ovf  <= 1'b0;
            end else begin
                r_out  <= w_sum;
                r_cout <= w_carry[WIDTH];
                r_ovf  <= w_ovf;
            end
        end

        assign out  = r_out;
        assign cout = r_cout;
        assign ovf  = r_ovf;
    end else begin : g_comb
        // Clock and reset have no function in the combinational build.
        logic w_unused;
        assign w_unused = sys_clk | sys_rst;

        assign out  = w_sum;
        assign cout = w_carry[WIDTH];
        assign ovf  = w_ovf;
    end

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// Bench for full_adder: 1-bit and 8-bit combinational instances plus an
// 8-bit registered instance, checked against an arithmetic reference model.
`default_nettype none

module tb_full_adder;

    logic       clk;
    logic       rst;

    logic       a1, b1, c1;
    logic       o1, co1, ov1;

    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] o8;
    logic       co8, ov8;

    logic [7:0] ar, br;
    logic       cr;
    logic [7:0] orr;
    logic       cor, ovr;

    int checks = 0;
    int errors = 0;

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_w1 (
        .sys_clk (1'b0), .sys_rst (1'b0),
        .a (a1), .b (b1), .cin (c1),
        .out (o1), .cout (co1), .ovf (ov1)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_w8 (
        .sys_clk (clk), .sys_rst (rst),
        .a (a8), .b (b8), .cin (c8),
        .out (o8), .cout (co8), .ovf (ov8)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (
        .sys_clk (clk), .sys_rst (rst),
        .a (ar), .b (br), .cin (cr),
        .out (orr), .cout (cor), .ovf (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, cout, out} from plain unsigned and signed sums.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int u, s;
        logic [8:0] us;
        u  = int'(a) + int'(b) + int'(c);
        s  = int'($signed(a)) + int'($signed(b)) + int'(c);
        us = u[8:0];
        return {(s > 127 || s < -128), us};
    endfunction

    function automatic logic [2:0] model1(input logic a, input logic b, input logic c);
        int u, s;
        logic [1:0] us;
        u  = int'(a) + int'(b) + int'(c);
        s  = -int'(a) - int'(b) + int'(c);
        us = u[1:0];
        return {(s > 0 || s < -1), us};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0] exp_r;

        rst = 1'b1;
        a1 = 0; b1 = 0; c1 = 0;
        a8 = 0; b8 = 0; c8 = 0;
        ar = 8'hA5; br = 8'h3C; cr = 1'b1;
        #2;
        check("reg_reset_state", {6'd0, ovr, cor, orr}, 16'h0);

        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = i[2:0];
            #1;
            check("w1_exhaustive", {13'd0, ov1, co1, o1}, {13'd0, model1(a1, b1, c1)});
        end
        {a1, b1, c1} = 3'b110;
        #1;
        check("w1_110", {14'd0, co1, o1}, 16'h2);
        {a1, b1, c1} = 3'b111;
        #1;
        check("w1_111", {14'd0, co1, o1}, 16'h3);

        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
        #1;
        check("w8_ff_plus_01", {6'd0, ov8, co8, o8}, 16'h100);
        a8 = 8'h7F; b8 = 8'h00; c8 = 1'b1;
        #1;
        check("w8_7f_plus_cin", {6'd0, ov8, co8, o8}, 16'h280);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        #1;
        check("w8_max", {7'd0, co8, o8}, 16'h1FF);

        for (int i = 0; i < 100; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            #10;
            check("w1_random", {13'd0, ov1, co1, o1}, {13'd0, model1(a1, b1, c1)});
        end

        for (int i = 0; i < 60; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            #3;
            check("w8_random", {6'd0, ov8, co8, o8}, {6'd0, model8(a8, b8, c8)});
        end

        // Registered instance: release reset with fresh operands present.
        @(negedge clk);
        check("reg_held_in_reset", {6'd0, ovr, cor, orr}, 16'h0);
        ar = 8'h12; br = 8'h34; cr = 1'b1;
        rst = 1'b0;
        #1;
        check("reg_before_edge", {6'd0, ovr, cor, orr}, 16'h0);
        @(posedge clk);
        #1;
        check("reg_12_34_1", {6'd0, ovr, cor, orr}, 16'h047);
        ar = 8'hF0; br = 8'hF0; cr = 1'b1;
        @(negedge clk);
        check("reg_hold_between_edges", {6'd0, ovr, cor, orr}, 16'h047);
        @(posedge clk);
        #1;
        exp_r = model8(8'hF0, 8'hF0, 1'b1);
        check("reg_f0_f0_1", {6'd0, ovr, cor, orr}, {6'd0, exp_r});

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ar = 8'($urandom); br = 8'($urandom); cr = 1'($urandom);
            #1;
            check("reg_random_hold", {6'd0, ovr, cor, orr}, {6'd0, exp_r});
            exp_r = model8(ar, br, cr);
            @(posedge clk);
            #1;
            check("reg_random", {6'd0, ovr, cor, orr}, {6'd0, exp_r});
        end

        // Reset in the middle of a cycle clears outputs without a clock edge.
        @(negedge clk);
        ar = 8'hC0; br = 8'hC0; cr = 1'b1;
        @(posedge clk);
        #1;
        check("reg_before_reset", {6'd0, ovr, cor, orr}, {6'd0, model8(8'hC0, 8'hC0, 1'b1)});
        #2;
        rst = 1'b1;
        #1;
        check("reg_async_reset", {6'd0, ovr, cor, orr}, 16'h0);
        @(posedge clk);
        #1;
        check("reg_reset_over_edge", {6'd0, ovr, cor, orr}, 16'h0);
        @(negedge clk);
        ar = 8'h0A; br = 8'h05; cr = 1'b0;
        rst = 1'b0;
        #1;
        check("reg_no_stale_value", {6'd0, ovr, cor, orr}, 16'h0);
        @(posedge clk);
        #1;
        check("reg_first_capture", {6'd0, ovr, cor, orr}, 16'h00F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
